// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, types and helpers for the RTC parameter reader
//
// Contents:
//   ADDR_*        RTC register addresses of the nine parameters
//   idx_t         read-order index (IDX_S..IDX_HT)
//   bus_phase_t   bus transaction FSM states
//   sweep_state_t sweep control FSM states
//   BUS_IDLE_*    bus levels while no transaction is active
//   param_addr()  index -> RTC register address
package rtc_pkg;

  localparam logic [7:0] ADDR_S  = 8'h21;
  localparam logic [7:0] ADDR_M  = 8'h22;
  localparam logic [7:0] ADDR_H  = 8'h23;
  localparam logic [7:0] ADDR_D  = 8'h24;
  localparam logic [7:0] ADDR_ME = 8'h25;
  localparam logic [7:0] ADDR_A  = 8'h26;
  localparam logic [7:0] ADDR_ST = 8'h41;
  localparam logic [7:0] ADDR_MT = 8'h42;
  localparam logic [7:0] ADDR_HT = 8'h43;

  localparam int NUM_PARAMS = 9;

  typedef enum logic [3:0] {
    IDX_S  = 4'd0,
    IDX_M  = 4'd1,
    IDX_H  = 4'd2,
    IDX_D  = 4'd3,
    IDX_ME = 4'd4,
    IDX_A  = 4'd5,
    IDX_ST = 4'd6,
    IDX_MT = 4'd7,
    IDX_HT = 4'd8
  } idx_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ADDR,
    PH_GAP1,
    PH_READ,
    PH_GAP2
  } bus_phase_t;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_COMMIT
  } sweep_state_t;

  localparam logic       BUS_IDLE_CS_N   = 1'b1;
  localparam logic       BUS_IDLE_RD_N   = 1'b1;
  localparam logic       BUS_IDLE_WR_N   = 1'b1;
  localparam logic       BUS_IDLE_AD_OE  = 1'b0;
  localparam logic       BUS_IDLE_A_D    = 1'b1;
  localparam logic [7:0] BUS_IDLE_AD_OUT = 8'h00;

  function automatic logic [7:0] param_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      IDX_S:   a = ADDR_S;
      IDX_M:   a = ADDR_M;
      IDX_H:   a = ADDR_H;
      IDX_D:   a = ADDR_D;
      IDX_ME:  a = ADDR_ME;
      IDX_A:   a = ADDR_A;
      IDX_ST:  a = ADDR_ST;
      IDX_MT:  a = ADDR_MT;
      IDX_HT:  a = ADDR_HT;
      default: a = ADDR_S;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_read_cycle.sv
// rtl/rtc_bus_read_cycle.sv - one ADDR/GAP1/READ/GAP2 read transaction on the RTC bus
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   go, addr          start a transaction for addr (accepted when idle or on the
//                     final GAP2 cycle, which chains transactions back to back)
//   ack               high on the final GAP2 cycle; data is valid then
//   data              byte captured on the final READ cycle
//   ad_in             data bus from the RTC
//   ad_out, ad_oe,
//   a_d, cs_n,
//   rd_n, wr_n        bus drive and strobes
module rtc_bus_read_cycle
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] addr,
  output logic       ack,
  output logic [7:0] data,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PHASE - 1);

  bus_phase_t       phase, phase_next;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_last;
  logic             go_accept;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;

  assign phase_last = (phase_cnt == CNT_LAST);
  assign data       = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= PH_IDLE;
      phase_cnt <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      phase     <= phase_next;
      // Every phase restarts the count; idle parks it at zero.
      phase_cnt <= (phase == PH_IDLE || phase_last) ? '0 : phase_cnt + CNT_W'(1);
      if (go_accept) addr_q <= addr;
      if (phase == PH_READ && phase_last) data_q <= ad_in;
    end
  end

  always_comb begin
    phase_next = phase;
    go_accept  = 1'b0;
    ack        = 1'b0;
    ad_out     = BUS_IDLE_AD_OUT;
    ad_oe      = BUS_IDLE_AD_OE;
    a_d        = BUS_IDLE_A_D;
    cs_n       = BUS_IDLE_CS_N;
    rd_n       = BUS_IDLE_RD_N;
    wr_n       = BUS_IDLE_WR_N;
    case (phase)
      PH_IDLE: begin
        if (go) begin
          go_accept  = 1'b1;
          phase_next = PH_ADDR;
        end
      end
      PH_ADDR: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        if (phase_last) phase_next = PH_GAP1;
      end
      PH_GAP1: begin
        // Address stays on the lines so the RTC latch sees a clean hold time.
        ad_out = addr_q;
        if (phase_last) phase_next = PH_READ;
      end
      PH_READ: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        a_d  = 1'b1;
        if (phase_last) phase_next = PH_GAP2;
      end
      PH_GAP2: begin
        if (phase_last) begin
          ack = 1'b1;
          if (go) begin
            go_accept  = 1'b1;
            phase_next = PH_ADDR;
          end else begin
            phase_next = PH_IDLE;
          end
        end
      end
      default: phase_next = PH_IDLE;
    endcase
  end

endmodule

// File: rtl/rtc_param_reader.sv
// rtl/rtc_param_reader.sv - reads the nine RTC parameters and commits them atomically
//
// Optional feature macro: RD_AUTO_REFRESH_EN (periodic internal start every
// REFRESH_CYCLES clocks, ORed with the external start).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               request a full read sweep (honoured only when idle)
//   busy, done          sweep in progress / one-cycle commit pulse
//   ad_in               data bus from the RTC
//   ad_out, ad_oe, a_d,
//   cs_n, rd_n, wr_n    RTC bus drive and strobes
//   s, m, h, d, me, a   clock/date BCD values
//   st, mt, ht          timer BCD values
module rtc_param_reader
  import rtc_pkg::*;
#(
  parameter int T_PHASE        = 4,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] s,
  output logic [7:0] m,
  output logic [7:0] h,
  output logic [7:0] d,
  output logic [7:0] me,
  output logic [7:0] a,
  output logic [7:0] st,
  output logic [7:0] mt,
  output logic [7:0] ht
);

  sweep_state_t sweep, sweep_next;
  logic [3:0]   idx, next_idx;
  logic         go, ack, start_req, last_ack;
  logic [7:0]   rd_data;
  logic [7:0]   shadow      [NUM_PARAMS];
  logic [7:0]   shadow_next [NUM_PARAMS];

`ifdef RD_AUTO_REFRESH_EN
  logic [31:0] ref_cnt;
  logic        refresh_tick;

  // Free-running: a tick while busy is simply lost because start_req is
  // only looked at in SW_IDLE.
  assign refresh_tick = (ref_cnt == 32'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) ref_cnt <= '0;
    else      ref_cnt <= refresh_tick ? '0 : ref_cnt + 32'd1;
  end

  assign start_req = start | refresh_tick;
`else
  assign start_req = start;
`endif

  rtc_bus_read_cycle #(
    .T_PHASE(T_PHASE)
  ) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .addr  (param_addr(next_idx)),
    .ack   (ack),
    .data  (rd_data),
    .ad_in (ad_in),
    .ad_out(ad_out),
    .ad_oe (ad_oe),
    .a_d   (a_d),
    .cs_n  (cs_n),
    .rd_n  (rd_n),
    .wr_n  (wr_n)
  );

  assign busy     = (sweep != SW_IDLE);
  assign done     = (sweep == SW_COMMIT);
  assign last_ack = (sweep == SW_RUN) && ack && (idx == 4'(IDX_HT));

  always_comb begin
    sweep_next = sweep;
    go         = 1'b0;
    next_idx   = idx + 4'd1;
    case (sweep)
      SW_IDLE: begin
        next_idx = 4'(IDX_S);
        if (start_req) begin
          go         = 1'b1;
          sweep_next = SW_RUN;
        end
      end
      SW_RUN: begin
        if (ack) begin
          if (idx == 4'(IDX_HT)) sweep_next = SW_COMMIT;
          else                   go         = 1'b1;
        end
      end
      SW_COMMIT: sweep_next = SW_IDLE;
      default:   sweep_next = SW_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_PARAMS; i++) shadow_next[i] = shadow[i];
    if (ack) shadow_next[idx] = rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sweep <= SW_IDLE;
      idx   <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
      {s, m, h, d, me, a, st, mt, ht} <= '0;
    end else begin
      sweep <= sweep_next;
      if (go)  idx <= next_idx;
      if (ack) begin
        for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= shadow_next[i];
      end
      // Outputs are loaded on the edge into SW_COMMIT so they are already
      // valid while done is high; shadow_next folds in the final byte.
      if (last_ack) begin
        s  <= shadow_next[IDX_S];
        m  <= shadow_next[IDX_M];
        h  <= shadow_next[IDX_H];
        d  <= shadow_next[IDX_D];
        me <= shadow_next[IDX_ME];
        a  <= shadow_next[IDX_A];
        st <= shadow_next[IDX_ST];
        mt <= shadow_next[IDX_MT];
        ht <= shadow_next[IDX_HT];
      end
    end
  end

endmodule

// File: tb/tb_rtc_param_reader.sv
// tb/tb_rtc_param_reader.sv - randomized self-checking bench for rtc_param_reader
module tb_rtc_param_reader;

`ifdef RD_AUTO_REFRESH_EN
  localparam int TP  = 1;
  localparam int REF = 200;
`else
  localparam int TP  = 4;
  localparam int REF = 100000;
`endif
  localparam int SWEEP_LEN = 36 * TP;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ad_in = 8'h00;
  logic       busy, done, ad_oe, a_d, cs_n, rd_n, wr_n;
  logic [7:0] ad_out, s, m, h, d, me, a, st, mt, ht;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int done_cnt = 0;
  int done_cyc_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] mem [256];
  logic [7:0] addr_tab [9];
  logic [7:0] bus_addr = 8'h00;
  logic       wr_prev = 1'b1;
  logic [71:0] exp_out = '0;

  rtc_param_reader #(.T_PHASE(TP), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .s(s), .m(m), .h(h), .d(d), .me(me), .a(a),
    .st(st), .mt(mt), .ht(ht)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC chip model: latches the address on the wr_n strobe, returns its
  // register contents while rd_n is low, and noise otherwise.
  always @(negedge clk) begin
    if (!rd_n && !wr_n) viol++;
    if (ad_oe && !rd_n) viol++;
    if (!wr_n && wr_prev) begin
      addr_q.push_back(ad_out);
      bus_addr = ad_out;
    end
    wr_prev = wr_n;
    if (!rd_n) ad_in = mem[bus_addr];
    else       ad_in = 8'($urandom);
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] outs();
    return {s, m, h, d, me, a, st, mt, ht};
  endfunction

  function automatic logic [71:0] expected_from_mem();
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], mem[addr_tab[i]]};
    return v;
  endfunction

  task automatic check_addr_order(input string tag);
    logic [71:0] got = '0;
    logic [71:0] want = '0;
    check({tag, "_addr_count"}, 72'(addr_q.size()), 72'd9);
    for (int i = 0; i < 9; i++) begin
      want = {want[63:0], addr_tab[i]};
      got  = {got[63:0], (i < addr_q.size()) ? addr_q[i] : 8'hxx};
    end
    check({tag, "_addr_order"}, got, want);
  endtask

  // One sweep; extra_off > 0 pulses a second start during cycle k+extra_off.
  task automatic do_sweep(input string tag, input int extra_off);
    int k;
    int done_at = -1;
    int base;
    bit torn = 0;
    logic [71:0] want;
    want = expected_from_mem();
    addr_q.delete();
    base = done_cnt;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < SWEEP_LEN + 40; n++) begin
      @(negedge clk);
      if (extra_off > 0 && cyc == k + extra_off) start = 1'b1;
      else start = 1'b0;
      if (cyc == k + 1) check({tag, "_busy_rise"}, 72'(busy), 72'd1);
      if (done && done_at < 0) begin
        done_at = cyc;
        check({tag, "_commit_values"}, outs(), want);
      end else if (done_at < 0 && outs() !== exp_out) begin
        torn = 1;
      end
      if (done_at >= 0 && cyc == done_at + 1) check({tag, "_busy_fall"}, 72'(busy), 72'd0);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 72'(done_at), 72'(k + 1 + SWEEP_LEN));
    check({tag, "_no_early_change"}, 72'(torn), 72'd0);
    check({tag, "_done_pulses"}, 72'(done_cnt - base), 72'd1);
    check_addr_order(tag);
    exp_out = want;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 9; i++) mem[addr_tab[i]] = 8'($urandom);
  endtask

  initial begin
    addr_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", outs(), 72'd0);
    check("rst_busy_done", 72'({busy, done}), 72'd0);
    check("rst_bus", 72'({cs_n, rd_n, wr_n, ad_oe, a_d}), 72'b11101);
    check("rst_ad_out", 72'(ad_out), 72'h00);
    @(posedge clk); #1;
    rst = 1'b1;

`ifdef RD_AUTO_REFRESH_EN
    randomize_mem();
    done_cyc_q.delete();
    repeat (3 * REF + 100) @(posedge clk);
    @(negedge clk);
    check("refresh_done_count", 72'(done_cyc_q.size()), 72'd3);
    if (done_cyc_q.size() >= 3) begin
      check("refresh_period_1", 72'(done_cyc_q[1] - done_cyc_q[0]), 72'(REF));
      check("refresh_period_2", 72'(done_cyc_q[2] - done_cyc_q[1]), 72'(REF));
    end
    check("refresh_values", outs(), expected_from_mem());
    check("refresh_protocol", 72'(viol), 72'd0);
`else
    mem[8'h21] = 8'h59; mem[8'h22] = 8'h45; mem[8'h23] = 8'h12;
    mem[8'h24] = 8'h31; mem[8'h25] = 8'h12; mem[8'h26] = 8'h16;
    mem[8'h41] = 8'h30; mem[8'h42] = 8'h15; mem[8'h43] = 8'h02;
    repeat (5) @(posedge clk);
    do_sweep("fixed", 0);

    randomize_mem();
    do_sweep("start_busy", 40);
    randomize_mem();
    do_sweep("start_commit", SWEEP_LEN + 1);

    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      repeat ($urandom_range(0, 7)) @(posedge clk);
      do_sweep("random", 0);
    end

    // Reset during the READ phase of index 4.
    begin
      bit found = 0;
      randomize_mem();
      addr_q.delete();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < SWEEP_LEN && !found; n++) begin
        @(negedge clk);
        if (addr_q.size() == 5 && !rd_n) found = 1;
      end
      check("midrst_reached_read4", 72'(found), 72'd1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_bus_idle", 72'({cs_n, rd_n, wr_n, ad_oe, a_d}), 72'b11101);
      check("midrst_busy", 72'(busy), 72'd0);
      check("midrst_outputs", outs(), 72'd0);
      exp_out = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      randomize_mem();
      do_sweep("after_rst", 0);
    end
    check("protocol", 72'(viol), 72'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_param_reader.md
Name: rtc_param_reader

Overview:
Reads the nine RTC parameters back from the external RTC chip over its multiplexed address/data bus. The parameters are seconds, minutes, hours, day, month, year, timer seconds, timer minutes and timer hours. It is the read-side counterpart to the parameter-modification path, which produces values to be written. Captured BCD bytes go to the display/VGA path. All nine outputs update atomically at the end of each full read sweep, so the display never shows a torn time.

Parameters:
T_PHASE, 4, clk cycles per bus phase (>=1)
REFRESH_CYCLES, 100000, auto-refresh period in clk cycles (used only with RD_AUTO_REFRESH_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle request to begin a full read sweep
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when outputs have been committed
ad_in  in  8  data bus from the RTC
ad_out  out  8  address driven to the RTC
ad_oe  out  1  1 = drive ad_out onto the bus
a_d  out  1  0 = address phase, 1 = data phase
cs_n  out  1  chip select, active-low
rd_n  out  1  read strobe, active-low
wr_n  out  1  write/address-latch strobe, active-low
s, m, h, d, me, a  out  8 each  clock/date BCD values
st, mt, ht  out  8 each  timer BCD values

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE; all parameter outputs 8'h00; busy=0; done=0.
  - Bus idle: cs_n=1, rd_n=1, wr_n=1, ad_oe=0, a_d=1, ad_out=8'h00.
  - Reset mid-sweep aborts immediately; shadow registers are discarded.
- Fixed read order, index 0..8, addresses from the package:
  - s=8'h21, m=8'h22, h=8'h23, d=8'h24, me=8'h25, a=8'h26
  - st=8'h41, mt=8'h42, ht=8'h43
- FSM states: IDLE -> ADDR -> GAP1 -> READ -> GAP2 -> (ADDR with next index | COMMIT) -> IDLE.
- Each of ADDR, GAP1, READ and GAP2 lasts exactly T_PHASE cycles, timed by a phase counter.
- ADDR: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=address[idx].
- GAP1 and GAP2: bus idle values. ad_out is held through GAP1.
- READ: cs_n=0, rd_n=0, a_d=1, ad_oe=0. ad_in is sampled into shadow[idx] on the last READ cycle only.
- COMMIT lasts one cycle:
  - all nine outputs load from shadow simultaneously;
  - done=1 for this cycle only;
  - busy falls on the next cycle.
- start is honoured only in IDLE. If start is seen at edge k:
  - busy=1 from k+1;
  - done pulses at cycle k+1+36*T_PHASE;
  - with T_PHASE=4, done is at k+145.
- start while busy is ignored, not queued. start coinciding with the COMMIT cycle is also ignored.
- rd_n and wr_n are never both low. ad_oe=1 only while rd_n=1.
- Captured data are not range-checked or converted; they pass through as raw BCD.
- The index counter stops after 8; there is no wrap within a sweep.

Optional Feature:
- Macro: RD_AUTO_REFRESH_EN.
- When defined:
  - a free-running counter issues an internal start every REFRESH_CYCLES cycles, ORed with the external start;
  - the counter keeps running while busy, and a tick landing during busy is dropped;
  - the counter resets to 0 on rst.
- When undefined: only the external start launches a sweep, and REFRESH_CYCLES is unused.

Decomposition:
- Package rtc_pkg holds:
  - the nine register address constants and the index enum (IDX_S..IDX_HT, 4 bits);
  - the FSM state typedef;
  - the bus-idle constant values.
- Sub-module rtc_bus_read_cycle:
  - performs one ADDR/GAP1/READ/GAP2 transaction for a given address;
  - handshake is go / ack plus an 8-bit data output;
  - it owns the phase counter.
- The top level owns the index counter, the shadow array, the COMMIT stage and the refresh counter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with a random bus -> all outputs 8'h00, cs_n=1, rd_n=1, wr_n=1, ad_oe=0, busy=0.
- Full sweep (T_PHASE=4): the bus model returns 8'h59, 8'h45, 8'h12, 8'h31, 8'h12, 8'h16, 8'h30, 8'h15, 8'h02 for the addresses in order. Pulse start at cycle 10 -> done at cycle 155. Outputs change only at 155, to exactly those values. The bus model checks address order 21..26, 41..43.
- Atomicity: start with all outputs 8'h00, then sample outputs each cycle during busy -> all stay 8'h00 until the COMMIT cycle.
- start during busy: a second pulse at cycle 50 -> exactly one done pulse and no restart of the index.
- Reset mid-sweep: rst=0 during READ of index 4 -> bus returns to idle on the next edge. Outputs are 8'h00, and a new sweep after reset reads from index 0.
- With RD_AUTO_REFRESH_EN, REFRESH_CYCLES=200, T_PHASE=1 -> done pulses every 200 cycles without any external start. No bus protocol violations (rd_n/wr_n overlap, ad_oe with rd_n=0) occur.
